// File: rtl/pe_wdb.sv
// pe_wdb: weight-stationary systolic processing element with double-buffered
// weights (shadow + active), a shift chain for weight loading, valid-tagged
// operands, signed/unsigned arithmetic and a sticky overflow flag.
// Optional build macro: PE_SAT_EN -- when defined, an overflowing partial sum
// clamps to the representable extreme instead of wrapping.
module pe_wdb #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  w_load,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic [DATA_WIDTH-1:0] w_out,
  input  logic                  w_swap,
  input  logic                  top_valid,
  input  logic [DATA_WIDTH-1:0] top_in,
  input  logic [ACC_WIDTH-1:0]  left_in,
  output logic                  down_valid,
  output logic [DATA_WIDTH-1:0] down_out,
  output logic [ACC_WIDTH-1:0]  partial_out,
  input  logic                  ovf_clr,
  output logic                  ovf
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int EXT = ACC_WIDTH - PW;

  // State registers
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;
  logic [DATA_WIDTH-1:0] w_out_q, w_out_d;
  logic [DATA_WIDTH-1:0] down_out_q, down_out_d;
  logic                  down_valid_q, down_valid_d;
  logic [ACC_WIDTH-1:0]  partial_q, partial_d;
  logic                  ovf_q, ovf_d;

  // Datapath intermediates
  logic [PW-1:0]        mult_a;
  logic [PW-1:0]        mult_b;
  logic [PW-1:0]        prod;
  logic                 prod_sign;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf_det;
  logic                 ovf_event;

`ifdef PE_SAT_EN
  logic [ACC_WIDTH-1:0] sat_val;
`endif

  // Widen the product to the accumulator width; when the product already
  // fills the accumulator there is nothing to extend.
  generate
    if (EXT > 0) begin : g_ext
      assign prod_ext = {{EXT{prod_sign}}, prod};
    end else begin : g_noext
      assign prod_ext = prod;
    end
  endgenerate

  // Multiply-accumulate: extend operands to the product width so the low
  // half of the product is correct for both signed and unsigned modes, then
  // add at one extra bit so the unsigned carry is visible.
  always_comb begin
    mult_a    = {{DATA_WIDTH{(SIGNED != 0) & active_q[DATA_WIDTH-1]}}, active_q};
    mult_b    = {{DATA_WIDTH{(SIGNED != 0) & top_in[DATA_WIDTH-1]}}, top_in};
    prod      = mult_a * mult_b;
    prod_sign = (SIGNED != 0) & prod[PW-1];
    addend    = top_valid ? prod_ext : '0;
    sum_wide  = {1'b0, left_in} + {1'b0, addend};
    sum       = sum_wide[ACC_WIDTH-1:0];
    if (SIGNED != 0) begin
      ovf_det = (left_in[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != left_in[ACC_WIDTH-1]);
    end else begin
      ovf_det = sum_wide[ACC_WIDTH];
    end
    ovf_event = top_valid & ovf_det;
  end

`ifdef PE_SAT_EN
  // Clamp value: in signed mode both addends share a sign on overflow, so the
  // sign of left_in tells which extreme to pin to.
  always_comb begin
    sat_val = '1;
    if (SIGNED != 0) begin
      if (left_in[ACC_WIDTH-1]) begin
        sat_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        sat_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end
`endif

  // Next-state: weight chain, swap, operand forwarding, partial sum, flag.
  always_comb begin
    shadow_d     = w_load ? w_in : shadow_q;
    w_out_d      = w_load ? shadow_q : w_out_q;
    active_d     = w_swap ? shadow_q : active_q;
    down_valid_d = top_valid;
    down_out_d   = top_valid ? top_in : down_out_q;
`ifdef PE_SAT_EN
    partial_d    = ovf_event ? sat_val : sum;
`else
    partial_d    = sum;
`endif
    if (ovf_event) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // All state clears immediately on reset, even mid-load or mid-stream.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shadow_q     <= '0;
      active_q     <= '0;
      w_out_q      <= '0;
      down_out_q   <= '0;
      down_valid_q <= 1'b0;
      partial_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      w_out_q      <= w_out_d;
      down_out_q   <= down_out_d;
      down_valid_q <= down_valid_d;
      partial_q    <= partial_d;
      ovf_q        <= ovf_d;
    end
  end

  assign w_out       = w_out_q;
  assign down_out    = down_out_q;
  assign down_valid  = down_valid_q;
  assign partial_out = partial_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_pe_wdb.sv
// tb_pe_wdb: directed bench for pe_wdb. One signed and one unsigned instance
// share all inputs; expected values are hand-computed constants.
module tb_pe_wdb;

  logic        clk;
  logic        aresetn;
  logic        w_load;
  logic [15:0] w_in;
  logic        w_swap;
  logic        top_valid;
  logic [15:0] top_in;
  logic [31:0] left_in;
  logic        ovf_clr;

  logic [15:0] s_w_out, s_down_out, u_w_out, u_down_out;
  logic        s_down_valid, s_ovf, u_down_valid, u_ovf;
  logic [31:0] s_partial, u_partial;

  int total;
  int bad;

`ifdef PE_SAT_EN
  localparam logic [31:0] EXP_POS    = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG    = 32'h8000_0000;
  localparam logic [31:0] EXP_UCARRY = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_POS    = 32'h8000_0010;
  localparam logic [31:0] EXP_NEG    = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_UCARRY = 32'h0000_0000;
`endif

  pe_wdb #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(1)) dut_s (
    .clk(clk), .aresetn(aresetn), .w_load(w_load), .w_in(w_in),
    .w_out(s_w_out), .w_swap(w_swap), .top_valid(top_valid),
    .top_in(top_in), .left_in(left_in), .down_valid(s_down_valid),
    .down_out(s_down_out), .partial_out(s_partial), .ovf_clr(ovf_clr),
    .ovf(s_ovf)
  );

  pe_wdb #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(0)) dut_u (
    .clk(clk), .aresetn(aresetn), .w_load(w_load), .w_in(w_in),
    .w_out(u_w_out), .w_swap(w_swap), .top_valid(top_valid),
    .top_in(top_in), .left_in(left_in), .down_valid(u_down_valid),
    .down_out(u_down_out), .partial_out(u_partial), .ovf_clr(ovf_clr),
    .ovf(u_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, return 1 time unit later.
  task automatic applyStimulus(input logic wl, input logic [15:0] wi,
                               input logic ws, input logic tv,
                               input logic [15:0] ti, input logic [31:0] li,
                               input logic oc);
    w_load    = wl;
    w_in      = wi;
    w_swap    = ws;
    top_valid = tv;
    top_in    = ti;
    left_in   = li;
    ovf_clr   = oc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    aresetn   = 1'b0;
    w_load    = 1'b0;
    w_in      = '0;
    w_swap    = 1'b0;
    top_valid = 1'b0;
    top_in    = '0;
    left_in   = '0;
    ovf_clr   = 1'b0;
    #3;
    $display("[TB] reset state");
    checkOutput("rst_partial", s_partial, 32'h0);
    checkOutput("rst_down_out", 32'(s_down_out), 32'h0);
    checkOutput("rst_down_valid", 32'(s_down_valid), 32'h0);
    checkOutput("rst_w_out", 32'(s_w_out), 32'h0);
    checkOutput("rst_ovf", 32'(s_ovf), 32'h0);
    #4;
    aresetn = 1'b1;

    $display("[TB] weight load and swap");
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    checkOutput("load_w_out5", 32'(s_w_out), 32'd5);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
    checkOutput("idle_down_valid", 32'(s_down_valid), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd2, 32'd1, 1'b0);
    checkOutput("active7_partial", s_partial, 32'd15);

    $display("[TB] basic compute");
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    checkOutput("load_w_out7", 32'(s_w_out), 32'd7);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd4, 32'd10, 1'b0);
    checkOutput("mac_partial", s_partial, 32'd22);
    checkOutput("mac_down_out", 32'(s_down_out), 32'd4);
    checkOutput("mac_down_valid", 32'(s_down_valid), 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 16'd99, 32'd9, 1'b0);
    checkOutput("pass_partial", s_partial, 32'd9);
    checkOutput("pass_down_out", 32'(s_down_out), 32'd4);
    checkOutput("pass_down_valid", 32'(s_down_valid), 32'd0);

    $display("[TB] swap timing");
    applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 16'd5, 32'd0, 1'b0);
    checkOutput("swap_old_weight", s_partial, 32'd15);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd5, 32'd0, 1'b0);
    checkOutput("swap_new_weight", s_partial, 32'd10);
    applyStimulus(1'b1, 16'd9, 1'b1, 1'b1, 16'd1, 32'd0, 1'b0);
    checkOutput("ldswap_w_out", 32'(s_w_out), 32'd2);
    checkOutput("ldswap_partial", s_partial, 32'd2);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd1, 32'd0, 1'b0);
    checkOutput("ldswap_active2", s_partial, 32'd2);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd1, 32'd0, 1'b0);
    checkOutput("ldswap_shadow9", s_partial, 32'd9);

    $display("[TB] signed overflow");
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'h0020, 32'h7FFF_FFF0, 1'b0);
    checkOutput("sovf_pos_partial", s_partial, EXP_POS);
    checkOutput("sovf_pos_flag", 32'(s_ovf), 32'd1);
    checkOutput("u_noovf_partial", u_partial, 32'h8000_0010);
    checkOutput("u_noovf_flag", 32'(u_ovf), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b1);
    checkOutput("ovf_clear", 32'(s_ovf), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'h0020, 32'h7FFF_FFF0, 1'b1);
    checkOutput("ovf_set_wins", 32'(s_ovf), 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b1);
    checkOutput("ovf_clear2", 32'(s_ovf), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'hFFFF, 32'h8000_0000, 1'b0);
    checkOutput("sovf_neg_partial", s_partial, EXP_NEG);
    checkOutput("sovf_neg_flag", 32'(s_ovf), 32'd1);
    checkOutput("u_neg_partial", u_partial, 32'h8000_FFFF);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b1);

    $display("[TB] unsigned mode");
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'hFFFF, 32'd0, 1'b0);
    checkOutput("u_prod_partial", u_partial, 32'hFFFE_0001);
    checkOutput("u_prod_flag", 32'(u_ovf), 32'd0);
    checkOutput("s_prod_partial", s_partial, 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'hFFFF, 32'h0001_FFFF, 1'b0);
    checkOutput("u_carry_partial", u_partial, EXP_UCARRY);
    checkOutput("u_carry_flag", 32'(u_ovf), 32'd1);
    checkOutput("s_nocarry_partial", s_partial, 32'h0002_0000);
    checkOutput("s_nocarry_flag", 32'(s_ovf), 32'd0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd2, 32'd5, 1'b0);
    checkOutput("stream_s_partial", s_partial, 32'd3);
    checkOutput("stream_u_partial", u_partial, 32'h0002_0003);
    checkOutput("u_ovf_sticky", 32'(u_ovf), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("mid_rst_partial", s_partial, 32'h0);
    checkOutput("mid_rst_u_partial", u_partial, 32'h0);
    checkOutput("mid_rst_down_out", 32'(s_down_out), 32'h0);
    checkOutput("mid_rst_down_valid", 32'(s_down_valid), 32'h0);
    checkOutput("mid_rst_w_out", 32'(s_w_out), 32'h0);
    checkOutput("mid_rst_u_ovf", 32'(u_ovf), 32'h0);
    #2;
    aresetn = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd7, 32'd3, 1'b0);
    checkOutput("post_rst_active0", s_partial, 32'd3);
    checkOutput("post_rst_u_active0", u_partial, 32'd3);
    checkOutput("post_rst_down_out", 32'(s_down_out), 32'd7);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 16'd7, 32'd3, 1'b0);
    checkOutput("post_rst_shadow0", s_partial, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_wdb.md
Name: pe_wdb

Overview:
- Weight-stationary systolic-array processing element. Multiplies the stationary weight by the operand arriving from the top, adds the partial sum arriving from the left, and registers both outputs onward.
- Adds the following over the single-register PE:
  - double-buffered weights (shadow and active), so the next weight tile loads while the current tile computes;
  - a cascaded shift chain for weight loading;
  - valid tagging of operands;
  - signed/unsigned mode;
  - a wide accumulator with sticky overflow detection.
- Tiled in a ROWS x COLS grid by the array top level.

Parameters:
- DATA_WIDTH, 16, width of weight and top operand.
- ACC_WIDTH, 32, width of the partial-sum path (must be >= 2*DATA_WIDTH).
- SIGNED, 1, 1 = two's-complement operands and sums; 0 = unsigned.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- w_load  in  1  shift the weight chain one step.
- w_in  in  DATA_WIDTH  weight from the PE above in the load chain (or from the array edge).
- w_out  out  DATA_WIDTH  registered shadow weight to the PE below in the chain.
- w_swap  in  1  copy the shadow weight into the active weight.
- top_valid  in  1  top_in carries a valid operand.
- top_in  in  DATA_WIDTH  operand from above.
- left_in  in  ACC_WIDTH  partial sum from the left.
- down_valid  out  1  registered top_valid.
- down_out  out  DATA_WIDTH  registered operand to below.
- partial_out  out  ACC_WIDTH  registered partial sum to the right.
- ovf_clr  in  1  clear the sticky overflow flag.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (asynchronous, aresetn low): shadow, active, w_out, down_out, partial_out = 0; down_valid = 0; ovf = 0. Takes effect immediately, including mid-stream or mid-load; no partial state survives.
- Weight chain:
  - On a clk edge with w_load = 1: shadow <= w_in, w_out <= old shadow. An N-deep column is loaded in N cycles.
  - w_load = 0: shadow and w_out hold.
- Swap:
  - On a clk edge with w_swap = 1: active <= shadow.
  - If w_load and w_swap are both 1 in the same cycle, active takes the pre-load shadow value.
  - A top_valid operand in the swap cycle uses the old active weight. The new weight applies from the next cycle.
- Compute (latency 1 cycle, every cycle):
  - down_valid <= top_valid.
  - If top_valid = 1: down_out <= top_in, and partial_out <= left_in + active*top_in.
  - If top_valid = 0: down_out holds, and partial_out <= left_in (pass-through, zero contribution).
- Arithmetic:
  - The product is 2*DATA_WIDTH wide and is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
  - The sum is computed at ACC_WIDTH+1 bits.
- Overflow detection:
  - SIGNED=1: overflow when both addends have equal sign and the result sign differs.
  - SIGNED=0: overflow on carry out of bit ACC_WIDTH-1.
- ovf behaviour:
  - Set on any valid-cycle overflow.
  - ovf_clr = 1 clears it.
  - If set and clear occur in the same cycle, set wins.
- Without saturation, partial_out wraps modulo 2^ACC_WIDTH.
- No backpressure: the array is fully synchronous and data advances every cycle.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined:
  - On overflow, partial_out clamps instead of wrapping.
  - SIGNED=1: max 2^(ACC_WIDTH-1)-1 on positive overflow, min -2^(ACC_WIDTH-1) on negative overflow.
  - SIGNED=0: all-ones.
  - ovf is still set.
- Undefined: wrap-around only.
- Both builds have identical ports and latency.

Test Plan:
- Reset and weight load:
  - Reset, then check all outputs are 0.
  - w_load with w_in=5, then w_in=7 over 2 cycles -> shadow=7, w_out=5.
  - w_swap -> active=7.
- Basic compute:
  - active=3, top_valid=1, top_in=4, left_in=10 -> next cycle partial_out=22, down_out=4, down_valid=1.
  - top_valid=0, left_in=9 -> partial_out=9, down_out holds 4, down_valid=0.
- Swap timing:
  - shadow=2, active=3; w_swap and top_valid together, top_in=5, left_in=0 -> partial_out=15.
  - Next cycle top_in=5 -> partial_out=10.
  - Load+swap in the same cycle with shadow=2, w_in=9 -> active=2, shadow=9.
- Signed overflow (SIGNED=1, ACC_WIDTH=32):
  - left_in=0x7FFFFFF0, active=1, top_in=0x0020 -> wrap build: partial_out=0x80000010, ovf=1.
  - Same stimulus, PE_SAT_EN build -> partial_out=0x7FFFFFFF, ovf=1.
  - ovf_clr -> ovf=0.
  - Overflow coinciding with ovf_clr -> ovf stays 1.
- Unsigned mode (SIGNED=0):
  - active=0xFFFF, top_in=0xFFFF, left_in=0 -> partial_out=0xFFFE0001, ovf=0.
  - left_in=0x0001FFFF with the same product -> carry out, ovf=1.
- Reset mid-stream:
  - Assert aresetn low asynchronously between edges during valid traffic -> outputs are 0 immediately, before the next clk edge, and active=0.
